// File: rtl/npu_act_pkg.sv
// Shared types and constants for the activation readout stream.
// Holds matrix geometry, element/matrix types, the streamer state enum and
// the derived index/count widths used by act_matrix_streamer and its counter.
package npu_act_pkg;

  localparam int unsigned ACT_ROWS   = 10;
  localparam int unsigned ACT_COLS   = 10;
  localparam int unsigned ACT_DATA_W = 16;

  localparam int unsigned ACT_ROW_W  = $clog2(ACT_ROWS);
  localparam int unsigned ACT_COL_W  = $clog2(ACT_COLS);
  localparam int unsigned ACT_NEG_W  = $clog2(ACT_ROWS * ACT_COLS + 1);

  typedef logic signed [ACT_DATA_W-1:0] act_elem_t;
  typedef act_elem_t [ACT_ROWS-1:0][ACT_COLS-1:0] act_matrix_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } act_strm_state_e;

endpackage

// File: rtl/act_matrix_streamer_if.sv
// Element stream bundle: valid/ready handshake plus data, indices and
// end markers. master = streamer side, slave = downstream consumer.
interface act_matrix_streamer_if;
  import npu_act_pkg::*;

  logic                 out_valid;
  logic                 out_ready;
  act_elem_t            out_data;
  logic [ACT_ROW_W-1:0] out_row;
  logic [ACT_COL_W-1:0] out_col;
  logic                 out_last_col;
  logic                 out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last_col, out_last,
    output out_ready
  );

endinterface

// File: rtl/act_rc_counter.sv
// Row-major row/col position counter with registered end flags.
// Ports: clk, rst (async active-low), clr (back to (0,0)), en (advance one
// element), row/col/last_col/last (registered position and flags),
// row_nxt_c/col_nxt_c (combinational position after the next advance).
module act_rc_counter
  import npu_act_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  output logic [ACT_ROW_W-1:0] row,
  output logic [ACT_COL_W-1:0] col,
  output logic                 last_col,
  output logic                 last,
  output logic [ACT_ROW_W-1:0] row_nxt_c,
  output logic [ACT_COL_W-1:0] col_nxt_c
);

  logic last_col_nxt;
  logic last_nxt;

  // Next position: col wraps on last column and carries into row; the row
  // wraps after the final element so the counter never leaves the matrix.
  always_comb begin
    col_nxt_c = last_col ? '0 : col + ACT_COL_W'(1);
    row_nxt_c = row;
    if (last_col) begin
      row_nxt_c = (row == ACT_ROW_W'(ACT_ROWS - 1)) ? '0 : row + ACT_ROW_W'(1);
    end
    last_col_nxt = (col_nxt_c == ACT_COL_W'(ACT_COLS - 1));
    last_nxt     = last_col_nxt && (row_nxt_c == ACT_ROW_W'(ACT_ROWS - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row      <= '0;
      col      <= '0;
      last_col <= 1'b0;
      last     <= 1'b0;
    end else if (clr) begin
      row      <= '0;
      col      <= '0;
      last_col <= (ACT_COLS == 1);
      last     <= (ACT_ROWS * ACT_COLS == 1);
    end else if (en) begin
      row      <= row_nxt_c;
      col      <= col_nxt_c;
      last_col <= last_col_nxt;
      last     <= last_nxt;
    end
  end

endmodule

// File: rtl/act_matrix_streamer.sv
// Snapshots the activation matrix on start and streams it row-major over a
// valid/ready handshake with row/col indices and end markers.
// Ports: clk, rst (async active-low), start (capture request, IDLE only),
// in_matrix (activation output), busy (capture .. done inclusive),
// done (one-cycle pulse after final transfer), strm (element stream, master).
// Optional: define ACT_NEG_COUNT_EN to add neg_count, the number of negative
// elements transferred in the current/last frame.
module act_matrix_streamer
  import npu_act_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  act_matrix_t           in_matrix,
  output logic                  busy,
  output logic                  done,
`ifdef ACT_NEG_COUNT_EN
  output logic [ACT_NEG_W-1:0]  neg_count,
`endif
  act_matrix_streamer_if.master strm
);

  act_strm_state_e      state;
  act_matrix_t          mat_q;
  logic                 xfer;
  logic                 capture;
  logic [ACT_ROW_W-1:0] row_nxt;
  logic [ACT_COL_W-1:0] col_nxt;

  assign xfer    = strm.out_valid && strm.out_ready;
  assign capture = (state == IDLE) && start;

  act_rc_counter u_rc (
    .clk       (clk),
    .rst       (rst),
    .clr       (capture),
    .en        (xfer),
    .row       (strm.out_row),
    .col       (strm.out_col),
    .last_col  (strm.out_last_col),
    .last      (strm.out_last),
    .row_nxt_c (row_nxt),
    .col_nxt_c (col_nxt)
  );

  // Control FSM and registered data path; out_data is preloaded with the
  // element at the counter's next position so it lines up with the indices.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      strm.out_valid <= 1'b0;
      strm.out_data  <= '0;
      mat_q          <= '0;
`ifdef ACT_NEG_COUNT_EN
      neg_count      <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mat_q          <= in_matrix;
            strm.out_data  <= in_matrix[0][0];
            strm.out_valid <= 1'b1;
            busy           <= 1'b1;
            state          <= STREAM;
`ifdef ACT_NEG_COUNT_EN
            neg_count      <= '0;
`endif
          end
        end
        STREAM: begin
          if (xfer) begin
            strm.out_data <= mat_q[row_nxt][col_nxt];
`ifdef ACT_NEG_COUNT_EN
            if (strm.out_data[ACT_DATA_W-1]) begin
              neg_count <= neg_count + ACT_NEG_W'(1);
            end
`endif
            if (strm.out_last) begin
              strm.out_valid <= 1'b0;
              done           <= 1'b1;
              state          <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
